// File: rtl/alu_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : alu_seq_if
// Purpose  : Request/result bundle between the control FSM and alu_seq.
//            The master issues operations; the slave (the ALU) returns
//            registered results with a ready/done handshake.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_hi;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;
  logic             dz;
  logic             err;

  modport master (
    output start, op, a, b, c_in,
    input  ready, done, r, r_hi, zero, neg, carry, ovf, dz, err
  );

  modport slave (
    input  start, op, a, b, c_in,
    output ready, done, r, r_hi, zero, neg, carry, ovf, dz, err
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : alu_seq
// Purpose  : Parametrised sequential ALU. Logic/add/shift ops complete in one
//            cycle; unsigned multiply (shift-add) and divide (restoring) take
//            WIDTH iterations. Results are registered and held between ops.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  wire logic clk,
  input  wire logic reset,
  alu_seq_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [SHW-1:0]   cnt;
  logic             is_div;
  logic [WIDTH-1:0] opd;   // multiplicand or divisor
  logic [WIDTH-1:0] hi;    // partial product high half / partial remainder
  logic [WIDTH-1:0] lo;    // multiplier (shifting out) / quotient (shifting in)

  logic [WIDTH-1:0] res, res_hi;
  logic             res_carry, res_ovf, res_dz, res_err;

  logic             accept, long_op, last;

  assign accept  = bus.start && (state != RUN);
  assign long_op = (bus.op == OP_MULU) || (bus.op == OP_DIVU);
  assign last    = (cnt == SHW'(WIDTH - 1));

  assign bus.ready = (state != RUN);
  assign bus.done  = (state == DONE);
  assign bus.r     = res;
  assign bus.r_hi  = res_hi;
  assign bus.zero  = (res == '0);
  assign bus.neg   = res[WIDTH-1];
  assign bus.carry = res_carry;
  assign bus.ovf   = res_ovf;
  assign bus.dz    = res_dz;
  assign bus.err   = res_err;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: DONE accepts a new request just like IDLE for back-to-back issue.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = long_op ? RUN : DONE;
      RUN:     if (last)   state_nx = DONE;
      DONE:    state_nx = accept ? (long_op ? RUN : DONE) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Single-cycle ops, evaluated straight from the request inputs at accept.
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_carry, alu_ovf, alu_err;

  always_comb begin
    is_sub    = (bus.op == OP_SUB);
    b_eff     = is_sub ? ~bus.b : bus.b;
    sum       = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.c_in};
    alu_r     = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (bus.op)
      OP_AND:  alu_r = bus.a & bus.b;
      OP_OR:   alu_r = bus.a | bus.b;
      OP_XOR:  alu_r = bus.a ^ bus.b;
      OP_NOR:  alu_r = ~(bus.a | bus.b);
      OP_SLL:  alu_r = bus.a << bus.b[SHW-1:0];
      OP_SRL:  alu_r = bus.a >> bus.b[SHW-1:0];
      OP_ADD, OP_SUB: begin
        alu_r     = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      default: alu_err = 1'b1;
    endcase
  end

  // One multiply or divide iteration. A zero divisor never borrows, so the
  // quotient fills with ones and the remainder collects the dividend.
  logic [WIDTH:0]   mul_add;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] hi_nx, lo_nx;

  always_comb begin
    mul_add  = {1'b0, hi} + {1'b0, (lo[0] ? opd : {WIDTH{1'b0}})};
    div_diff = {hi, lo[WIDTH-1]} - {1'b0, opd};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        hi_nx = div_diff[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = {hi[WIDTH-2:0], lo[WIDTH-1]};
        lo_nx = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nx = mul_add[WIDTH:1];
      lo_nx = {mul_add[0], lo[WIDTH-1:1]};
    end
  end

  // Operand latching, iteration and result registers (held until next completion).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      is_div    <= 1'b0;
      opd       <= '0;
      hi        <= '0;
      lo        <= '0;
      res       <= '0;
      res_hi    <= '0;
      res_carry <= 1'b0;
      res_ovf   <= 1'b0;
      res_dz    <= 1'b0;
      res_err   <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      is_div <= (bus.op == OP_DIVU);
      hi     <= '0;
      opd    <= (bus.op == OP_DIVU) ? bus.b : bus.a;
      lo     <= (bus.op == OP_DIVU) ? bus.a : bus.b;
      if (!long_op) begin
        res       <= alu_r;
        res_hi    <= '0;
        res_carry <= alu_carry;
        res_ovf   <= alu_ovf;
        res_dz    <= 1'b0;
        res_err   <= alu_err;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      hi  <= hi_nx;
      lo  <= lo_nx;
      if (last) begin
        res       <= lo_nx;
        res_hi    <= hi_nx;
        res_carry <= 1'b0;
        res_ovf   <= 1'b0;
        res_dz    <= is_div && (opd == '0);
        res_err   <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_alu_seq
// Purpose  : Directed self-checking bench for alu_seq (WIDTH=32 and WIDTH=8).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_alu_seq;
  localparam logic [3:0] AND_OP = 4'b0000;
  localparam logic [3:0] OR_OP  = 4'b0001;
  localparam logic [3:0] ADD_OP = 4'b0010;
  localparam logic [3:0] XOR_OP = 4'b0011;
  localparam logic [3:0] SUB_OP = 4'b0100;
  localparam logic [3:0] SLL_OP = 4'b0101;
  localparam logic [3:0] SRL_OP = 4'b0110;
  localparam logic [3:0] NOR_OP = 4'b0111;
  localparam logic [3:0] MUL_OP = 4'b1000;
  localparam logic [3:0] DIV_OP = 4'b1001;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  alu_seq #(.WIDTH(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ci);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = ci;
  endtask

  task automatic drive8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus8.start = 1'b1;
    bus8.op    = op;
    bus8.a     = a;
    bus8.b     = b;
    bus8.c_in  = 1'b0;
  endtask

  initial begin
    logic seen;
    int   low_cnt;
    logic early;

    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
    bus8.start = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0; bus8.c_in = 1'b0;
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_r",     bus.r,          32'd0);
    check("rst_r_hi",  bus.r_hi,       32'd0);
    check("rst_zero",  32'(bus.zero),  32'd1);
    check("rst_flags", 32'({bus.neg, bus.carry, bus.ovf, bus.dz, bus.err}), 32'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    step;

    // ADD signed overflow
    drive(ADD_OP, 32'h7FFF_FFFF, 32'd1, 1'b0);
    step;
    bus.start = 1'b0;
    check("add_done", 32'(bus.done), 32'd1);
    check("add_r",    bus.r, 32'h8000_0000);
    check("add_zncv", 32'({bus.zero, bus.neg, bus.carry, bus.ovf}), 32'b0101);

    // Reset during RUN of a MULU: abort, no done
    drive(MUL_OP, 32'd7, 32'd9, 1'b0);
    step;
    bus.start = 1'b0;
    repeat (10) step;
    check("mul_run_ready", 32'(bus.ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_ready", 32'(bus.ready), 32'd1);
    check("arst_done",  32'(bus.done),  32'd0);
    check("arst_r",     bus.r,          32'd0);
    check("arst_zero",  32'(bus.zero),  32'd1);
    @(negedge clk) reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      step;
      if (bus.done) seen = 1'b1;
    end
    check("arst_no_done", 32'(seen), 32'd0);

    // SUB equal operands
    drive(SUB_OP, 32'd5, 32'd5, 1'b1);
    step;
    bus.start = 1'b0;
    check("sub_done", 32'(bus.done), 32'd1);
    check("sub_r",    bus.r, 32'd0);
    check("sub_zncv", 32'({bus.zero, bus.neg, bus.carry, bus.ovf}), 32'b1010);

    // ADD with carry-in wrapping to zero
    drive(ADD_OP, 32'hFFFF_FFFF, 32'd0, 1'b1);
    step;
    bus.start = 1'b0;
    check("addc_r",    bus.r, 32'd0);
    check("addc_zncv", 32'({bus.zero, bus.neg, bus.carry, bus.ovf}), 32'b1010);

    // MULU max*max with an ignored start mid-RUN
    drive(MUL_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    step;
    bus.start = 1'b0;
    low_cnt = 0;
    early   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!bus.ready) low_cnt++;
      if (bus.done) early = 1'b1;
      if (i == 10) drive(AND_OP, 32'd1, 32'd1, 1'b0);
      if (i == 11) bus.start = 1'b0;
      step;
    end
    check("mul_ready_low", 32'(low_cnt), 32'd32);
    check("mul_no_early",  32'(early),   32'd0);
    check("mul_done",      32'(bus.done), 32'd1);
    check("mul_r",         bus.r,    32'h0000_0001);
    check("mul_r_hi",      bus.r_hi, 32'hFFFF_FFFE);
    check("mul_flags",     32'({bus.carry, bus.ovf, bus.dz, bus.err}), 32'd0);
    step;
    check("mul_done_drop", 32'(bus.done),  32'd0);
    check("mul_ready_back", 32'(bus.ready), 32'd1);

    // DIVU 100/7
    drive(DIV_OP, 32'd100, 32'd7, 1'b0);
    step;
    bus.start = 1'b0;
    repeat (31) step;
    check("div_not_yet", 32'(bus.done), 32'd0);
    step;
    check("div_done", 32'(bus.done), 32'd1);
    check("div_q",    bus.r,    32'd14);
    check("div_rem",  bus.r_hi, 32'd2);
    check("div_dz",   32'(bus.dz), 32'd0);

    // DIVU by zero
    drive(DIV_OP, 32'd100, 32'd0, 1'b0);
    step;
    bus.start = 1'b0;
    repeat (31) step;
    step;
    check("dz_done", 32'(bus.done), 32'd1);
    check("dz_r",    bus.r,    32'hFFFF_FFFF);
    check("dz_r_hi", bus.r_hi, 32'd100);
    check("dz_flag", 32'({bus.dz, bus.neg}), 32'b11);
    step;
    check("dz_hold_r",  bus.r,         32'hFFFF_FFFF);
    check("dz_hold_dz", 32'(bus.dz),   32'd1);

    // Back-to-back SLL, SRL, NOR
    drive(SLL_OP, 32'd1, 32'd31, 1'b0);
    step;
    check("sll_done", 32'(bus.done), 32'd1);
    check("sll_r",    bus.r, 32'h8000_0000);
    drive(SRL_OP, 32'h8000_0000, 32'd4, 1'b0);
    step;
    check("srl_done", 32'(bus.done), 32'd1);
    check("srl_r",    bus.r, 32'h0800_0000);
    drive(NOR_OP, 32'd0, 32'd0, 1'b0);
    step;
    bus.start = 1'b0;
    check("nor_done", 32'(bus.done), 32'd1);
    check("nor_r",    bus.r, 32'hFFFF_FFFF);
    step;
    check("b2b_idle", 32'(bus.done), 32'd0);

    // Illegal op
    drive(4'b1100, 32'd123, 32'd45, 1'b0);
    step;
    bus.start = 1'b0;
    check("ill_done", 32'(bus.done), 32'd1);
    check("ill_err",  32'(bus.err),  32'd1);
    check("ill_r",    bus.r,    32'd0);
    check("ill_r_hi", bus.r_hi, 32'd0);

    // WIDTH=8 logic ops
    drive8(AND_OP, 8'hF0, 8'h3C);
    step;
    check("w8_and_done", 32'(bus8.done), 32'd1);
    check("w8_and", 32'(bus8.r), 32'h30);
    drive8(OR_OP, 8'hF0, 8'h3C);
    step;
    check("w8_or", 32'(bus8.r), 32'hFC);
    drive8(XOR_OP, 8'hF0, 8'h3C);
    step;
    bus8.start = 1'b0;
    check("w8_xor", 32'(bus8.r), 32'hCC);
    check("w8_neg", 32'(bus8.neg), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU: the successor to the 32-bit single-cycle ALU, generalised to any power-of-two width. It adds registered outputs with a start/done handshake and iterative unsigned multiply and divide. It sits between the register file read ports and the write-back mux in the multicycle datapath. The control FSM issues one operation at a time and waits for `done`.

## Interface
- `WIDTH`, 32, operand/result width; power of two, ≥ 4
- `SHW`, $clog2(WIDTH), shift-amount width (derived; do not override)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears all state and outputs
- `start`  in  1  request; accepted when `start & ready` at a rising edge
- `op`  in  4  operation code, sampled on accept
- `a`, `b`  in  WIDTH  operands, sampled on accept
- `c_in`  in  1  carry-in for ADD/SUB, sampled on accept
- `ready`  out  1  block can accept a request
- `done`  out  1  one-cycle pulse: `r`, `r_hi` and flags are valid
- `r`  out  WIDTH  result (low product / quotient for MUL/DIV)
- `r_hi`  out  WIDTH  high product / remainder; 0 for all other ops
- `zero`  out  1  `r == 0`
- `neg`  out  1  `r[WIDTH-1]`
- `carry`  out  1  carry-out, ADD/SUB only, else 0
- `ovf`  out  1  signed overflow, ADD/SUB only, else 0
- `dz`  out  1  divide by zero (DIVU with `b == 0`), else 0
- `err`  out  1  illegal op code, else 0

## Operation
Op codes (`op[2:0]` for `op[3]=0` keeps the legacy select encoding):
- 0000 AND
- 0001 OR
- 0010 ADD: `a + b + c_in`
- 0011 XOR
- 0100 SUB: `a + ~b + c_in`; `c_in=1` gives `a-b`
- 0101 SLL: `a << b[SHW-1:0]`
- 0110 SRL: `a >> b[SHW-1:0]`, logical
- 0111 NOR
- 1000 MULU: unsigned, 2·WIDTH-bit product, shift-add iterative
- 1001 DIVU: unsigned restoring division
- 1010–1111: illegal

Arithmetic rules:
- ADD/SUB:
  - `carry` = bit WIDTH of the WIDTH+1-bit sum.
  - `ovf` = (sign a' == sign b') & (sign r != sign a'), where b' is `b` for ADD and `~b` for SUB.
- DIVU with `b == 0`: `r` = all ones, `r_hi = a`, `dz = 1`. This is the natural restoring-divider outcome, with the same latency.
- Illegal op: `r = r_hi = 0`, `err = 1`, latency 1.

State machine:
- States: IDLE, RUN, DONE.
- IDLE: on accept, go to DONE for basic/illegal ops, or to RUN for MULU/DIVU. Operands are latched and the iteration counter is cleared.
- RUN: performs one iteration per cycle. After the WIDTH-th iteration, load the result registers and go to DONE.
- DONE: `done=1` for this one cycle only.
  - Without `start`, go to IDLE.
  - With `start`, accept the new request exactly as IDLE would (back-to-back issue).
- `ready = (state != RUN)`.
- `start` while in RUN is ignored and not queued.

Output holding:
- `r`, `r_hi` and all flags update only on the edge that enters DONE.
- They hold their values until the next completion, so they remain readable after `done` drops.
- `zero` and `neg` always track the registered `r`.

## Timing
- Reset (asynchronous assert, any state):
  - State returns to IDLE.
  - Counter is cleared.
  - `r = r_hi = 0`, `done = 0`, `ready = 1`.
  - `zero = 1`, `neg = carry = ovf = dz = err = 0`.
  - An in-flight MUL/DIV is discarded and no `done` is produced.
- Accept edge k:
  - Basic ops: `done` high during cycle k+1 (latency 1).
  - MULU/DIVU: `done` high during cycle k+WIDTH+1. There are WIDTH RUN cycles, and `ready` is low throughout them.
- Back-to-back: accept at the DONE-cycle edge. Throughput is 1 op/cycle for basic ops.
- Inputs are don't-care except at the accept edge.

## Test plan
- Reset mid-MULU (WIDTH=32, `a=7`, `b=9`, reset in RUN cycle 10) -> immediate IDLE, `ready=1`, `r=0`, `zero=1`, and no `done` pulse within the next 40 cycles.
- ADD `a=32'h7FFFFFFF`, `b=1`, `c_in=0` -> `done` one cycle later, `r=32'h80000000`, `ovf=1`, `carry=0`, `neg=1`. Then SUB `a=5`, `b=5`, `c_in=1` -> `r=0`, `zero=1`, `carry=1`, `ovf=0`.
- MULU `a=32'hFFFFFFFF`, `b=32'hFFFFFFFF` -> `ready` low for 32 cycles, `done` at accept+33, `r=32'h00000001`, `r_hi=32'hFFFFFFFE`. `start` pulsed mid-RUN must be ignored.
- DIVU `a=100`, `b=7` -> `r=14`, `r_hi=2`, latency 33. DIVU `a=100`, `b=0` -> `r=32'hFFFFFFFF`, `r_hi=100`, `dz=1`.
- Back-to-back: SLL `a=1`, `b=31` -> `r=32'h80000000`. Then SRL (`b=4`) issued in the DONE cycle -> `r=32'h08000000` one cycle later. Then NOR `a=0`, `b=0` -> `r=32'hFFFFFFFF`. Expect three consecutive `done` pulses.
- Op 1100 -> `err=1`, `r=0`, `r_hi=0`, `done` after 1 cycle. Repeat AND/OR/XOR with WIDTH=8 instance: `a=8'hF0`, `b=8'h3C` -> `8'h30`, `8'hFC`, `8'hCC`.
